// File: rtl/seg_scan_sched.sv
// Multiplexed 8-segment LED scan scheduler with a double-buffered pattern memory.
// Latency: all outputs registered; a committed pattern appears on digit 0 of the next frame.
// Backpressure: wr_ready drops after a commit and rises again with frame_tick.
//
// Ports:
//   clk, reset      - system clock, asynchronous active-low reset
//   wr_valid/ready  - pattern write handshake; wr_addr selects digit, wr_data is the active-low pattern
//   wr_commit       - one-cycle pulse requesting a shadow-to-active swap at the next frame boundary
//   bright          - PWM duty in sixteenths of the show window
//   segout          - registered active-low segment drive (bit7 = dp)
//   scanout         - registered binary digit select
//   frame_tick      - one-cycle pulse on the cycle after the buffer swap
module seg_scan_sched #(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 65536,
  parameter int BLANK_CYC = 256,
  parameter int CW        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       wr_commit,
  input  logic [3:0] bright,
  output logic [7:0] segout,
  output logic [2:0] scanout,
  output logic       frame_tick
);

  localparam logic [0:0]    ST_BLANK   = 1'b0;
  localparam logic [0:0]    ST_SHOW    = 1'b1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [2:0]    SCAN_LAST  = 3'(DIGITS - 1);
  localparam logic [3:0]    DIGITS_W   = 4'(DIGITS);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [3:0]    pwm_q, pwm_d;
  logic [3:0]    bright_q, bright_d;
  logic [2:0]    scan_q, scan_d;
  logic [7:0]    seg_q, seg_d;
  logic          pend_q, pend_d;
  logic          tick_q;

  // Sized to the full 3-bit address space so any index is in range;
  // only entries below DIGITS are ever written or displayed.
  logic [7:0]    active_q [8];
  logic [7:0]    shadow_q [8];

  logic slot_end;
  logic frame_end;
  logic swap;
  logic wr_hit;

  assign slot_end  = (state_q == ST_SHOW) && (slot_q == SLOT_LAST);
  assign frame_end = slot_end && (scan_q == SCAN_LAST);
  // Only a commit registered before the boundary cycle triggers the swap.
  assign swap      = frame_end & pend_q;
  assign wr_hit    = wr_valid & ~pend_q & ({1'b0, wr_addr} < DIGITS_W);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    pwm_d    = pwm_q;
    bright_d = bright_q;
    scan_d   = scan_q;
    case (state_q)
      ST_BLANK: begin
        slot_d = slot_q + CW'(1);
        if (slot_q == BLANK_LAST) begin
          state_d  = ST_SHOW;
          pwm_d    = 4'd0;
          bright_d = bright;
        end
      end
      default: begin
        pwm_d = pwm_q + 4'd1;
        if (slot_end) begin
          slot_d  = '0;
          state_d = ST_BLANK;
          scan_d  = (scan_q == SCAN_LAST) ? 3'd0 : scan_q + 3'd1;
        end else begin
          slot_d = slot_q + CW'(1);
        end
      end
    endcase

    // Segment drive is computed from next state so segout lines up with state_q.
    // The swap only happens when entering BLANK, so active_q is settled before any SHOW cycle reads it.
    if ((state_d == ST_SHOW) && (pwm_d < bright_d)) begin
      seg_d = active_q[scan_d];
    end else begin
      seg_d = 8'hFF;
    end

    // A commit on the boundary cycle itself is carried into the next frame;
    // a commit while one is already pending is absorbed.
    if (frame_end) begin
      pend_d = ~pend_q & wr_commit;
    end else begin
      pend_d = pend_q | wr_commit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BLANK;
      slot_q   <= '0;
      pwm_q    <= 4'd0;
      bright_q <= 4'd0;
      scan_q   <= 3'd0;
      seg_q    <= 8'hFF;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        active_q[i] <= 8'hFF;
        shadow_q[i] <= 8'hFF;
      end
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
      scan_q   <= scan_d;
      seg_q    <= seg_d;
      pend_q   <= pend_d;
      tick_q   <= swap;
      if (wr_hit) begin
        shadow_q[wr_addr] <= wr_data;
      end
      if (swap) begin
        for (int i = 0; i < DIGITS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign wr_ready   = ~pend_q;
  assign segout     = seg_q;
  assign scanout    = scan_q;
  assign frame_tick = tick_q;

endmodule
